// File: rtl/link_len_table.sv
// rtl/link_len_table.sv - programmable link-ID to message-length lookup table
// Runtime-written length table with a clear sweep and a 2-stage valid/ready lookup pipeline.
module link_len_table #(
    parameter int ID_W    = 6,
    parameter int LEN_W   = 13,
    parameter int ID_BASE = 3,
    parameter int N_ENTRY = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cfg_we,
    input  logic [ID_W-1:0]  cfg_id,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_clr,
    output logic             cfg_err,
    output logic             busy,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_id,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [LEN_W-1:0] rsp_len,
    output logic             rsp_hit
);
    localparam int IDX_W = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
    localparam logic [ID_W:0]    ID_LO  = (ID_W+1)'(ID_BASE);
    localparam logic [ID_W:0]    ID_HI  = (ID_W+1)'(ID_BASE + N_ENTRY);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRY - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_ENTRY-1:0] vld_q;
    logic [LEN_W-1:0]   len_q [N_ENTRY];

    logic               s1_valid_q, s1_hit_q;
    logic [LEN_W-1:0]   s1_len_q;
    logic               rsp_valid_q, rsp_hit_q;
    logic [LEN_W-1:0]   rsp_len_q;
    logic               cfg_err_q;

    // Offsets are one bit wider than the ID so IDs below ID_BASE cannot wrap into range.
    logic [ID_W:0]      cfg_off, req_off;
    logic [IDX_W-1:0]   cfg_idx, req_idx;
    logic               cfg_in_range, req_in_range;
    logic               wr_ok, adv, accept;
    logic               rd_hit;
    logic [LEN_W-1:0]   rd_len;

    assign cfg_off      = {1'b0, cfg_id} - ID_LO;
    assign req_off      = {1'b0, req_id} - ID_LO;
    assign cfg_idx      = cfg_off[IDX_W-1:0];
    assign req_idx      = req_off[IDX_W-1:0];
    assign cfg_in_range = ({1'b0, cfg_id} >= ID_LO) && ({1'b0, cfg_id} < ID_HI);
    assign req_in_range = ({1'b0, req_id} >= ID_LO) && ({1'b0, req_id} < ID_HI);

    assign wr_ok  = cfg_we && cfg_in_range && (state_q == ST_IDLE) && !cfg_clr;
    assign adv    = !rsp_valid_q || rsp_ready;
    assign accept = req_valid && req_ready;
    assign rd_hit = req_in_range && vld_q[req_idx];
    assign rd_len = rd_hit ? len_q[req_idx] : '0;

    assign req_ready = adv && (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CLEAR);
    assign cfg_err   = cfg_err_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_len   = rsp_len_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_clr) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cfg_err_q <= cfg_we && !wr_ok;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q <= '0;
            for (int i = 0; i < N_ENTRY; i++) begin
                len_q[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            vld_q[idx_q] <= 1'b0;
            len_q[idx_q] <= '0;
        end else if (wr_ok) begin
            vld_q[cfg_idx] <= 1'b1;
            len_q[cfg_idx] <= cfg_len;
        end
    end

    // S1 samples the table before any same-edge write lands; both stages stall together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_len_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_len_q   <= '0;
        end else if (adv) begin
            s1_valid_q  <= accept;
            s1_hit_q    <= rd_hit;
            s1_len_q    <= rd_len;
            rsp_valid_q <= s1_valid_q;
            rsp_hit_q   <= s1_hit_q;
            rsp_len_q   <= s1_len_q;
        end
    end
endmodule

// File: tb/tb_link_len_table.sv
// tb/tb_link_len_table.sv - self-checking bench for link_len_table
// Reference model: per-ID length/valid arrays, an in-flight scoreboard queue and a clear countdown.
module tb_link_len_table;
    localparam int ID_W    = 6;
    localparam int LEN_W   = 13;
    localparam int ID_BASE = 3;
    localparam int N_ENTRY = 32;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             cfg_we, cfg_clr, cfg_err, busy;
    logic [ID_W-1:0]  cfg_id;
    logic [LEN_W-1:0] cfg_len;
    logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_hit;
    logic [ID_W-1:0]  req_id;
    logic [LEN_W-1:0] rsp_len;

    link_len_table #(.ID_W(ID_W), .LEN_W(LEN_W), .ID_BASE(ID_BASE), .N_ENTRY(N_ENTRY)) dut (
        .clk(clk), .n_rst(n_rst),
        .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_len(cfg_len), .cfg_clr(cfg_clr),
        .cfg_err(cfg_err), .busy(busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_len(rsp_len), .rsp_hit(rsp_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [LEN_W-1:0] m_len [1<<ID_W];
    logic             m_vld [1<<ID_W];
    logic [LEN_W:0]   sb [$];
    int               clr_left;
    logic             m_s1, m_s2, err_pend, stall_pend, last_acc;
    logic [LEN_W:0]   stall_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic in_rng(input int id);
        return (id >= ID_BASE) && (id < ID_BASE + N_ENTRY);
    endfunction

    function automatic logic [LEN_W:0] exp_of(input logic [ID_W-1:0] id);
        if (in_rng(int'(id)) && m_vld[id]) return {1'b1, m_len[id]};
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1<<ID_W); i++) begin
            m_len[i] = '0;
            m_vld[i] = 1'b0;
        end
        sb.delete();
        clr_left = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
        err_pend = 1'b0; stall_pend = 1'b0; last_acc = 1'b0;
        stall_val = '0;
    endtask

    // Called just after a falling edge with inputs already driven; advances one clock.
    task automatic tick();
        logic adv, acc, wr;
        logic [LEN_W:0] e;
        #1;
        chk("busy", busy, clr_left > 0);
        chk("rsp_valid", rsp_valid, m_s2);
        adv = !m_s2 || rsp_ready;
        chk("req_ready", req_ready, adv && clr_left == 0);
        chk("cfg_err", cfg_err, err_pend);
        if (stall_pend) chk("rsp_stable", {rsp_hit, rsp_len}, stall_val);
        if (m_s2 && rsp_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 0, 1);
            else begin
                e = sb.pop_front();
                chk("rsp_data", {rsp_hit, rsp_len}, e);
            end
        end
        stall_pend = rsp_valid && !rsp_ready;
        stall_val  = {rsp_hit, rsp_len};
        acc = req_valid && adv && clr_left == 0;
        last_acc = acc;
        if (acc) sb.push_back(exp_of(req_id));
        wr = cfg_we && in_rng(int'(cfg_id)) && clr_left == 0 && !cfg_clr;
        err_pend = cfg_we && !wr;
        @(posedge clk);
        if (wr) begin
            m_len[cfg_id] = cfg_len;
            m_vld[cfg_id] = 1'b1;
        end
        if (clr_left > 0) clr_left--;
        else if (cfg_clr) begin
            clr_left = N_ENTRY;
            for (int i = 0; i < (1<<ID_W); i++) begin
                m_len[i] = '0;
                m_vld[i] = 1'b0;
            end
        end
        if (adv) begin
            m_s2 = m_s1;
            m_s1 = acc;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_clr = 0; cfg_id = '0; cfg_len = '0;
        req_valid = 0; req_id = '0; rsp_ready = 1;
    endtask

    task automatic cfg_write(input int id, input int len);
        cfg_we = 1; cfg_id = ID_W'(id); cfg_len = LEN_W'(len);
        tick();
        cfg_we = 0;
    endtask

    task automatic request(input int id);
        req_valid = 1; req_id = ID_W'(id);
        tick();
        req_valid = 0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (4) tick();
    endtask

    int ids3 [3] = '{4, 5, 34};
    int k, nacc;

    initial begin
        idle_inputs();
        model_reset();
        n_rst = 0;
        repeat (2) @(negedge clk);
        n_rst = 1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_len", rsp_len, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge clk);

        // Miss before any write, with the response two stages after acceptance.
        request(4);
        tick();
        chk("lat_rsp_valid", rsp_valid, 1);
        drain();

        cfg_write(4, 'h03b8);
        cfg_write(5, 'h0120);
        cfg_write(34, 'h1040);
        foreach (ids3[i]) begin
            req_valid = 1; req_id = ID_W'(ids3[i]); tick();
        end
        request(2);
        drain();

        // Backpressure: only two requests fit while the output is stalled.
        rsp_ready = 0; k = 0; nacc = 0;
        repeat (4) begin
            req_valid = 1; req_id = ID_W'(ids3[k]);
            tick();
            if (last_acc) begin k++; nacc++; end
        end
        chk("stall_accepts", nacc, 2);
        rsp_ready = 1;
        for (int g = 0; g < 10 && k < 3; g++) begin
            req_valid = 1; req_id = ID_W'(ids3[k]);
            tick();
            if (last_acc) k++;
        end
        chk("stall_all_sent", k, 3);
        drain();

        // A same-edge write is invisible to the request accepted on that edge.
        cfg_we = 1; cfg_id = 7; cfg_len = 'h0420; req_valid = 1; req_id = 7;
        tick();
        cfg_we = 0;
        request(7);
        drain();

        cfg_clr = 1; tick(); cfg_clr = 0;
        repeat (5) tick();
        cfg_write(9, 'h0555);
        cfg_clr = 1; tick(); cfg_clr = 0;
        repeat (N_ENTRY) tick();
        request(4);
        request(9);
        drain();

        cfg_write(4, 'h0011);
        cfg_write(2, 'h0aaa);
        cfg_write(35, 'h0bbb);
        cfg_we = 1; cfg_id = 6; cfg_len = 'h0ccc; cfg_clr = 1;
        tick();
        cfg_we = 0; cfg_clr = 0;
        repeat (N_ENTRY + 1) tick();
        request(2); request(35); request(6); request(63);
        drain();

        cfg_write(4, 'h0077);
        cfg_clr = 1; tick(); cfg_clr = 0;
        repeat (6) tick();
        n_rst = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        model_reset();
        @(negedge clk);
        n_rst = 1;
        request(4);
        drain();

        for (int c = 0; c < 2000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_id    = ID_W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_id    = ID_W'($urandom_range(0, 40));
            cfg_len   = LEN_W'($urandom);
            cfg_clr   = ($urandom_range(0, 299) == 0);
            tick();
        end
        drain();
        chk("sb_empty_end", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
